// File: rtl/coeff_mem_arbiter.sv
// rtl/coeff_mem_arbiter.sv - shares one coefficient RAM between core reads and host requests
// Core reads always win the read port; host writes wait until no frame is being computed.
module coeff_mem_arbiter #(
  parameter int DW = 36,
  parameter int AW = 10,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_start,
  input  logic          frame_done,
  input  logic          core_rd_en,
  input  logic [AW-1:0] core_rd_addr,
  output logic [DW-1:0] core_rd_data,
  input  logic          host_req_valid,
  input  logic          host_req_we,
  input  logic [AW-1:0] host_req_addr,
  input  logic [DW-1:0] host_req_wdata,
  output logic          host_req_ready,
  output logic          host_rsp_valid,
  output logic [DW-1:0] host_rsp_rdata,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          in_frame,
  output logic [SW-1:0] host_stall_cnt
);

  typedef enum logic {ST_OPEN = 1'b0, ST_FRAME = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_hold_q, rsp_hold_d;
  logic          core_pend_q, core_pend_d;
  logic [DW-1:0] core_hold_q, core_hold_d;
  logic          fwd_hit_q, fwd_hit_d;
  logic [DW-1:0] fwd_data_q, fwd_data_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          host_rd_acc;
  logic [DW-1:0] rd_word;

  // frame_done is applied before frame_start, so a coincident pair always ends in FRAME
  always_comb begin
    state_d = state_q;
    if (state_q == ST_FRAME && frame_done) state_d = ST_OPEN;
    if (frame_start)                       state_d = ST_FRAME;
  end

  always_comb begin
    host_req_ready = host_req_we ? (state_q == ST_OPEN) : !core_rd_en;
    host_rd_acc    = host_req_valid && !host_req_we && host_req_ready;
    mem_rd_en      = core_rd_en || (host_req_valid && !host_req_we);
    mem_rd_addr    = core_rd_en ? core_rd_addr : host_req_addr;
    mem_wr_en      = host_req_valid && host_req_we && host_req_ready;
    mem_wr_addr    = host_req_addr;
    mem_wr_data    = host_req_wdata;
    in_frame       = (state_q == ST_FRAME);
    host_stall_cnt = stall_q;
  end

  // Write-first forwarding: the RAM returns old data on a collision
  always_comb begin
    fwd_hit_d  = mem_rd_en && mem_wr_en && (mem_rd_addr == mem_wr_addr);
    fwd_data_d = fwd_hit_d ? mem_wr_data : fwd_data_q;
    rd_word    = fwd_hit_q ? fwd_data_q : mem_rd_data;
  end

  always_comb begin
    rsp_valid_d    = host_rd_acc;
    rsp_hold_d     = rsp_valid_q ? rd_word : rsp_hold_q;
    host_rsp_valid = rsp_valid_q;
    host_rsp_rdata = rsp_valid_q ? rd_word : rsp_hold_q;
    core_pend_d    = core_rd_en;
    core_hold_d    = core_pend_q ? rd_word : core_hold_q;
    core_rd_data   = core_pend_q ? rd_word : core_hold_q;
    stall_d        = stall_q;
    if (host_req_valid && !host_req_ready && stall_q != {SW{1'b1}}) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_OPEN;
      rsp_valid_q <= 1'b0;
      rsp_hold_q  <= '0;
      core_pend_q <= 1'b0;
      core_hold_q <= '0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hold_q  <= rsp_hold_d;
      core_pend_q <= core_pend_d;
      core_hold_q <= core_hold_d;
      fwd_hit_q   <= fwd_hit_d;
      fwd_data_q  <= fwd_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_coeff_mem_arbiter.sv
// tb/tb_coeff_mem_arbiter.sv - directed self-checking bench for coeff_mem_arbiter
// Includes a 1-cycle-latency RAM model that returns old data on a read/write collision.
module tb_coeff_mem_arbiter;

  localparam int DW = 36;
  localparam int AW = 10;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_start, frame_done;
  logic          core_rd_en;
  logic [AW-1:0] core_rd_addr;
  logic [DW-1:0] core_rd_data;
  logic          host_req_valid, host_req_we;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_wdata;
  logic          host_req_ready;
  logic          host_rsp_valid;
  logic [DW-1:0] host_rsp_rdata;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          in_frame;
  logic [SW-1:0] host_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  coeff_mem_arbiter #(.DW(DW), .AW(AW), .SW(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start), .frame_done(frame_done),
    .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .host_req_valid(host_req_valid), .host_req_we(host_req_we),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_req_ready(host_req_ready), .host_rsp_valid(host_rsp_valid),
    .host_rsp_rdata(host_rsp_rdata),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .in_frame(in_frame), .host_stall_cnt(host_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Host payload must not change while a request is stalled
  logic          stall_prev = 1'b0;
  logic [AW+DW:0] payload_prev;
  always @(posedge clk) begin
    if (reset_n && stall_prev && host_req_valid)
      check("host_payload_stable", {host_req_we, host_req_addr, host_req_wdata}, payload_prev);
    stall_prev   <= reset_n && host_req_valid && !host_req_ready;
    payload_prev <= {host_req_we, host_req_addr, host_req_wdata};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    frame_start = 0; frame_done = 0; core_rd_en = 0; core_rd_addr = '0;
    host_req_valid = 0; host_req_we = 0; host_req_addr = '0; host_req_wdata = '0;
  endtask

  task automatic host(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req_valid = 1; host_req_we = we; host_req_addr = a; host_req_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    mem_rd_data = '0;
    idle();
    reset_n = 0;
    repeat (2) step();
    settle();
    check("rst_in_frame", in_frame, 0);
    check("rst_rsp_valid", host_rsp_valid, 0);
    check("rst_rsp_rdata", host_rsp_rdata, 0);
    check("rst_stall_cnt", host_stall_cnt, 0);
    check("rst_ready", host_req_ready, 1);
    reset_n = 1;

    // 1: write then read back
    step(); host(1, 5, 36'h123456789); settle();
    check("t1_wr_en", mem_wr_en, 1);
    check("t1_wr_addr", mem_wr_addr, 5);
    check("t1_wr_data", mem_wr_data, 36'h123456789);
    step(); idle(); settle();
    check("t1_wr_en_off", mem_wr_en, 0);
    check("t1_no_rsp_for_wr", host_rsp_valid, 0);
    host(0, 5, '0); settle();
    check("t1_rd_ready", host_req_ready, 1);
    check("t1_rd_addr", mem_rd_addr, 5);
    step(); idle(); settle();
    check("t1_rsp_valid", host_rsp_valid, 1);
    check("t1_rsp_rdata", host_rsp_rdata, 36'h123456789);
    step(); settle();
    check("t1_rsp_pulse", host_rsp_valid, 0);
    check("t1_rsp_hold", host_rsp_rdata, 36'h123456789);

    // 2: core priority over host read
    host(1, 7, 36'h777);
    step(); idle();
    core_rd_en = 1; core_rd_addr = 5; host(0, 7, '0); settle();
    check("t2_ready_blocked", host_req_ready, 0);
    check("t2_rd_addr_core", mem_rd_addr, 5);
    step(); settle();
    check("t2_stall1", host_stall_cnt, 1);
    check("t2_core_data", core_rd_data, 36'h123456789);
    step(); settle();
    check("t2_stall2", host_stall_cnt, 2);
    step(); core_rd_en = 0; settle();
    check("t2_ready_open", host_req_ready, 1);
    check("t2_rd_addr_host", mem_rd_addr, 7);
    check("t2_stall3", host_stall_cnt, 3);
    step(); idle(); settle();
    check("t2_rsp_valid", host_rsp_valid, 1);
    check("t2_rsp_rdata", host_rsp_rdata, 36'h777);
    check("t2_core_hold", core_rd_data, 36'h123456789);

    // 3: write held off during a frame
    frame_start = 1;
    step(); frame_start = 0; host(1, 3, 36'h333); settle();
    check("t3_in_frame", in_frame, 1);
    check("t3_ready_frame", host_req_ready, 0);
    check("t3_wr_blocked", mem_wr_en, 0);
    step(); settle();
    check("t3_still_blocked", mem_wr_en, 0);
    step(); frame_done = 1; settle();
    check("t3_done_cycle_blocked", host_req_ready, 0);
    step(); frame_done = 0; settle();
    check("t3_open_again", in_frame, 0);
    check("t3_wr_lands", mem_wr_en, 1);
    check("t3_stall6", host_stall_cnt, 6);
    step(); idle(); host(0, 3, '0);
    step(); idle(); settle();
    check("t3_readback", host_rsp_rdata, 36'h333);

    // 4: write/read collision is forwarded
    host(1, 9, 36'hABC); core_rd_en = 1; core_rd_addr = 9; settle();
    check("t4_wr_en", mem_wr_en, 1);
    step(); idle(); settle();
    check("t4_fwd_core", core_rd_data, 36'hABC);

    // 5: coincident frame_start/frame_done
    frame_done = 1; step(); frame_done = 0; settle();
    check("t5_done_in_open", in_frame, 0);
    frame_start = 1; frame_done = 1; step(); settle();
    check("t5_both_open", in_frame, 1);
    step(); frame_start = 0; frame_done = 0; settle();
    check("t5_both_frame", in_frame, 1);
    frame_start = 1; step(); frame_start = 0; settle();
    check("t5_start_in_frame", in_frame, 1);
    frame_done = 1; step(); frame_done = 0; settle();
    check("t5_done", in_frame, 0);

    // stall counter saturation
    core_rd_en = 1; host(0, 1, '0);
    repeat (65540) @(posedge clk);
    #1; settle();
    check("sat_stall", host_stall_cnt, 16'hFFFF);
    step(); idle();

    // 6: reset mid-frame with a read in flight
    frame_start = 1; step(); frame_start = 0; host(0, 5, '0); settle();
    check("t6_rd_ok_in_frame", host_req_ready, 1);
    @(posedge clk); #1; idle();
    reset_n = 0; settle();
    check("t6_state_open", in_frame, 0);
    check("t6_rsp_dropped", host_rsp_valid, 0);
    check("t6_stall_clr", host_stall_cnt, 0);
    step(); reset_n = 1; step(); settle();
    check("t6_after_rsp", host_rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
